joy_serial_reader: RTL and testbench
====================================

Name: joy_serial_reader

Overview:
- Parametrised successor to the fixed 2-player, 26-slot serial joystick reader in the arcade tops.
- Drives JOY_CLK/JOY_LOAD to an external parallel-in/serial-out joystick adapter and deserialises JOY_DATA into N active-low player words.
- Adds a JOY_DATA synchroniser, clock-enable pause, frame-consistency debounce and frame/change strobes.
- Sits in each core top; its outputs feed the remap to core I_JOYSTICK/I_COIN/I_PLAYER/reset inputs.

Parameters:
NUM_PLAYERS, 2, number of player words per frame (1..4)
BITS_PER_PLAYER, 12, bits captured per player
LEAD_BITS, 1, discarded slots between the load slot and the first data slot
SHIFT_DIV, 16, I_CLK cycles per JOY_CLK half-period (>=4)
DEBOUNCE_FRAMES, 2, identical consecutive frames required before O_JOY updates (>=1)

Ports:
I_CLK  in  1  core clock; all logic on its rising edge
I_RESET  in  1  asynchronous, active-high reset
I_ENA  in  1  when low, divider and frame sequencing freeze; outputs hold
JOY_DATA  in  1  serial data from adapter, asynchronous
JOY_CLK  out  1  shift clock to adapter, registered
JOY_LOAD  out  1  active-low parallel load to adapter, registered
O_JOY  out  NUM_PLAYERS*BITS_PER_PLAYER  debounced words, active-low, player 0 in the LSB word
O_FRAME  out  1  one-cycle pulse per completed frame
O_CHANGED  out  1  one-cycle pulse when O_JOY changes value

Behaviour:
- TOTAL = 1 + LEAD_BITS + NUM_PLAYERS*BITS_PER_PLAYER slots per frame (defaults give 26).
- Reset values: JOY_CLK=0, JOY_LOAD=1, O_JOY=all ones, O_FRAME=0, O_CHANGED=0. Divider, slot counter and debounce counter = 0. Raw and previous-raw registers = all ones.
- Sync: JOY_DATA passes through 2 flops; only the synchronised value is sampled.
- Divider: counts 0..SHIFT_DIV-1 while I_ENA=1. A tick occurs at SHIFT_DIV-1; the counter wraps and JOY_CLK toggles. A tick where JOY_CLK goes 0->1 is a rise tick.
- First rise tick is at the SHIFT_DIV-th enabled cycle after reset release.
- At each rise tick, with pre-increment slot s:
  - JOY_LOAD <= (s != 0), so JOY_LOAD is low for exactly one JOY_CLK period per frame.
  - Slots 1..LEAD_BITS: sample discarded.
  - Slot s >= 1+LEAD_BITS: raw[s-1-LEAD_BITS] <= synced data. Bit index i belongs to player i/BITS_PER_PLAYER, bit i%BITS_PER_PLAYER.
  - s wraps to 0 after TOTAL-1; otherwise s increments.
- FSM (slot-derived): LOAD (s=0) -> SKIP (1..LEAD_BITS; bypassed if LEAD_BITS=0) -> SHIFT -> COMMIT -> LOAD.
- COMMIT lasts one I_CLK cycle, entered on the cycle after the rise tick that captures the last bit. It executes regardless of I_ENA and does not stall the divider. In COMMIT:
  - O_FRAME=1.
  - If raw == prev_raw: stable counter saturating-increments, else stable <= 1.
  - prev_raw <= raw.
  - When stable (post-update) >= DEBOUNCE_FRAMES and raw != O_JOY: O_JOY <= raw on the same edge, O_CHANGED pulses the following cycle.
  - DEBOUNCE_FRAMES=1 updates on every frame.
- I_ENA low: divider, JOY_CLK, JOY_LOAD and slot hold; the synchroniser keeps running. Resume continues mid-frame with no lost or duplicated slot.
- Reset mid-frame: everything returns to reset values immediately (async). The partial frame is discarded; the next frame starts at slot 0.
- Unplugged adapter (constant 1) keeps O_JOY all ones. No O_CHANGED is produced after reset.

Decomposition:
- Package joy_pkg: slot/state encoding (LOAD, SKIP, SHIFT, COMMIT), TOTAL computation function, active-low idle constant.
- Sub-module joy_debounce: prev_raw compare, stable counter, O_JOY/O_CHANGED registers, parametrised by width and DEBOUNCE_FRAMES.
- Divider, synchroniser and slot FSM stay in the top.

Test Plan:
- Defaults, SHIFT_DIV=4, I_ENA=1: JOY_CLK period 8 cycles; JOY_LOAD low for exactly 8 cycles every 208 cycles; first O_FRAME after 26 rise ticks.
- Adapter model shifting 24'hA5C_3F0 (player1:player0), DEBOUNCE_FRAMES=2: O_JOY stays FFFFFF after frame 1, becomes A5C3F0 at COMMIT of frame 2, O_CHANGED one pulse.
- Single-frame glitch of bit 5 to 0 in one frame only, DEBOUNCE_FRAMES=2: O_JOY unchanged, no O_CHANGED, O_FRAME still every frame.
- I_ENA low for 37 cycles at slot 13: JOY_CLK/JOY_LOAD frozen; resulting word equals the no-pause result; frame length grows by exactly 37 cycles.
- I_RESET pulsed at slot 10: outputs return to reset values that cycle; next JOY_LOAD low occurs SHIFT_DIV cycles after release.
- NUM_PLAYERS=4, BITS_PER_PLAYER=8, LEAD_BITS=0, DEBOUNCE_FRAMES=1: 33 slots; pattern 32'h0123_4567 appears in O_JOY after one frame.

Source files
------------

// File: rtl/joy_pkg.sv
`default_nettype none
//==============================================================================
// joy_pkg : shared encodings and helpers for the serial joystick reader
// Revision: 1.0
//==============================================================================
package joy_pkg;

   localparam int c_state_w = 2;

   localparam logic [c_state_w-1:0] c_st_load   = 2'd0;
   localparam logic [c_state_w-1:0] c_st_skip   = 2'd1;
   localparam logic [c_state_w-1:0] c_st_shift  = 2'd2;
   localparam logic [c_state_w-1:0] c_st_commit = 2'd3;

   // Joystick words are active-low, so an idle bit reads as 1.
   localparam logic c_idle_bit = 1'b1;

   function automatic int joy_total(input int num_players, input int bits_per_player,
                                    input int lead_bits);
      return 1 + lead_bits + num_players * bits_per_player;
   endfunction

endpackage
`default_nettype wire

// File: rtl/joy_debounce.sv
`default_nettype none
//==============================================================================
// joy_debounce : frame-consistency filter producing the published joystick word
// Revision: 1.0
//==============================================================================
module joy_debounce
   import joy_pkg::*;
#(
   parameter int WIDTH           = 24,
   parameter int DEBOUNCE_FRAMES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_commit,
   input  logic [WIDTH-1:0] i_raw,
   output logic [WIDTH-1:0] o_joy,
   output logic             o_changed
);

   localparam int                 c_cnt_w = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(DEBOUNCE_FRAMES);

   logic [WIDTH-1:0]   r_prev;
   logic [WIDTH-1:0]   r_joy;
   logic [c_cnt_w-1:0] r_stable;
   logic               r_changed;

   logic               w_same;
   logic [c_cnt_w-1:0] w_stable_next;
   logic               w_update;

   // The counter only needs to reach the threshold, so it saturates there.
   always_comb begin
      w_same        = (i_raw == r_prev);
      w_stable_next = c_cnt_w'(1);
      if (w_same) begin
         w_stable_next = (r_stable == c_max) ? r_stable : r_stable + c_cnt_w'(1);
      end
      w_update = (w_stable_next >= c_max) && (i_raw != r_joy);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev    <= {WIDTH{c_idle_bit}};
         r_joy     <= {WIDTH{c_idle_bit}};
         r_stable  <= '0;
         r_changed <= 1'b0;
      end else begin
         r_changed <= i_commit && w_update;
         if (i_commit) begin
            r_prev   <= i_raw;
            r_stable <= w_stable_next;
            if (w_update) begin
               r_joy <= i_raw;
            end
         end
      end
   end

   assign o_joy     = r_joy;
   assign o_changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/joy_serial_reader.sv
`default_nettype none
//==============================================================================
// joy_serial_reader : drives a PISO joystick adapter and deserialises N players
// Revision: 1.0
//==============================================================================
module joy_serial_reader
   import joy_pkg::*;
#(
   parameter int NUM_PLAYERS     = 2,
   parameter int BITS_PER_PLAYER = 12,
   parameter int LEAD_BITS       = 1,
   parameter int SHIFT_DIV       = 16,
   parameter int DEBOUNCE_FRAMES = 2
) (
   input  logic                                   I_CLK,
   input  logic                                   I_RESET,
   input  logic                                   I_ENA,
   input  logic                                   JOY_DATA,
   output logic                                   JOY_CLK,
   output logic                                   JOY_LOAD,
   output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] O_JOY,
   output logic                                   O_FRAME,
   output logic                                   O_CHANGED
);

   localparam int c_width      = NUM_PLAYERS * BITS_PER_PLAYER;
   localparam int c_total      = joy_total(NUM_PLAYERS, BITS_PER_PLAYER, LEAD_BITS);
   localparam int c_slot_w     = $clog2(c_total);
   localparam int c_div_w      = $clog2(SHIFT_DIV);
   localparam int c_first_data = 1 + LEAD_BITS;

   logic [1:0]           r_sync;
   logic [c_div_w-1:0]   r_div;
   logic                 r_joy_clk;
   logic                 r_joy_load;
   logic [c_slot_w-1:0]  r_slot;
   logic [c_width-1:0]   r_raw;
   logic [c_state_w-1:0] r_state;

   logic                 w_data;
   logic                 w_tick;
   logic                 w_rise;
   logic                 w_last_slot;
   logic                 w_capture;
   logic [c_slot_w-1:0]  w_bit_idx;
   logic [c_state_w-1:0] w_state_next;
   logic                 w_commit;

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         r_sync <= {2{c_idle_bit}};
      end else begin
         r_sync <= {r_sync[0], JOY_DATA};
      end
   end

   assign w_data      = r_sync[1];
   assign w_tick      = I_ENA && (r_div == c_div_w'(SHIFT_DIV - 1));
   assign w_rise      = w_tick && !r_joy_clk;
   assign w_last_slot = (r_slot == c_slot_w'(c_total - 1));
   assign w_capture   = w_rise && (r_slot >= c_slot_w'(c_first_data));
   assign w_bit_idx   = r_slot - c_slot_w'(c_first_data);

   // Everything advances only on I_ENA, so a pause resumes mid-frame intact.
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         r_div      <= '0;
         r_joy_clk  <= 1'b0;
         r_joy_load <= 1'b1;
         r_slot     <= '0;
      end else begin
         if (I_ENA) begin
            r_div <= w_tick ? '0 : r_div + c_div_w'(1);
         end
         if (w_tick) begin
            r_joy_clk <= ~r_joy_clk;
         end
         if (w_rise) begin
            r_joy_load <= (r_slot != '0);
            r_slot     <= w_last_slot ? '0 : r_slot + c_slot_w'(1);
         end
      end
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         r_raw <= {c_width{c_idle_bit}};
      end else begin
         for (int i = 0; i < c_width; i++) begin
            if (w_capture && (w_bit_idx == c_slot_w'(i))) begin
               r_raw[i] <= w_data;
            end
         end
      end
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         r_state <= c_st_load;
      end else begin
         r_state <= w_state_next;
      end
   end

   // COMMIT always falls back to LOAD after one cycle, independent of I_ENA.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_load: begin
            if (w_rise) begin
               w_state_next = (LEAD_BITS > 0) ? c_st_skip : c_st_shift;
            end
         end
         c_st_skip: begin
            if (w_rise && (r_slot == c_slot_w'(LEAD_BITS))) begin
               w_state_next = c_st_shift;
            end
         end
         c_st_shift: begin
            if (w_rise && w_last_slot) begin
               w_state_next = c_st_commit;
            end
         end
         c_st_commit: begin
            w_state_next = c_st_load;
         end
         default: begin
            w_state_next = c_st_load;
         end
      endcase
   end

   always_comb begin
      w_commit = 1'b0;
      if (r_state == c_st_commit) begin
         w_commit = 1'b1;
      end
   end

   joy_debounce #(
      .WIDTH           (c_width),
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) u_debounce (
      .clk       (I_CLK),
      .rst       (I_RESET),
      .i_commit  (w_commit),
      .i_raw     (r_raw),
      .o_joy     (O_JOY),
      .o_changed (O_CHANGED)
   );

   assign JOY_CLK  = r_joy_clk;
   assign JOY_LOAD = r_joy_load;
   assign O_FRAME  = w_commit;

endmodule
`default_nettype wire

// File: tb/tb_joy_serial_reader.sv
`default_nettype none
//==============================================================================
// tb_joy_serial_reader : self-checking bench for joy_serial_reader
// Revision: 1.0
//==============================================================================
module tb_joy_serial_reader;

   localparam int SD    = 4;
   localparam int LEAD  = 1;
   localparam int DEB   = 2;
   localparam int W     = 24;
   localparam int TOTAL = 26;
   localparam int W2    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ena = 1'b1;
   logic          jdata = 1'b1;
   logic          jclk, jload, oframe, ochg;
   logic [W-1:0]  ojoy;

   logic          rst2 = 1'b1;
   logic          ena2 = 1'b1;
   logic          jdata2 = 1'b1;
   logic          jclk2, jload2, oframe2, ochg2;
   logic [W2-1:0] ojoy2;

   int total_n = 0;
   int bad_n   = 0;
   int cyc     = 0;
   int chg_count = 0;
   int load_run = 0;
   int last_low = 0;
   logic done2 = 1'b0;

   logic [W-1:0]  next_pat  = '1;
   logic [W-1:0]  fpat      = '1;
   logic [W2-1:0] next_pat2 = '1;
   logic [W2-1:0] fpat2     = '1;

   always #5 clk = ~clk;

   joy_serial_reader #(
      .NUM_PLAYERS(2), .BITS_PER_PLAYER(12), .LEAD_BITS(LEAD),
      .SHIFT_DIV(SD), .DEBOUNCE_FRAMES(DEB)
   ) dut (
      .I_CLK(clk), .I_RESET(rst), .I_ENA(ena), .JOY_DATA(jdata),
      .JOY_CLK(jclk), .JOY_LOAD(jload), .O_JOY(ojoy),
      .O_FRAME(oframe), .O_CHANGED(ochg)
   );

   joy_serial_reader #(
      .NUM_PLAYERS(4), .BITS_PER_PLAYER(8), .LEAD_BITS(0),
      .SHIFT_DIV(SD), .DEBOUNCE_FRAMES(1)
   ) dut2 (
      .I_CLK(clk), .I_RESET(rst2), .I_ENA(ena2), .JOY_DATA(jdata2),
      .JOY_CLK(jclk2), .JOY_LOAD(jload2), .O_JOY(ojoy2),
      .O_FRAME(oframe2), .O_CHANGED(ochg2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      total_n++;
      if (act !== exp_v) begin
         bad_n++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Adapter data for slot t: lead slots and anything past the word read idle.
   function automatic logic slot_bit(input int t, input int lead, input int w,
                                     input logic [63:0] p);
      if (t >= 1 + lead && t - 1 - lead < w) return p[t-1-lead];
      return 1'b1;
   endfunction

   initial forever @(posedge clk) cyc++;

   initial forever begin
      @(negedge clk);
      if (ochg) chg_count++;
      if (!jload) load_run++;
      else begin
         if (load_run > 0) last_low = load_run;
         load_run = 0;
      end
   end

   // Adapter for dut: latches the pattern on the load slot, presents one bit per rise.
   initial begin : p_adapter1
      int   k;
      logic pj;
      k = 0;
      pj = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            k = 0; jdata = 1'b1; pj = 1'b0;
         end else begin
            if (jclk && !pj) begin
               if (!jload) begin
                  k = 0;
                  fpat = next_pat;
               end else k++;
               jdata = slot_bit(k + 1, LEAD, W, 64'(fpat));
            end
            pj = jclk;
         end
      end
   end

   initial begin : p_adapter2
      int   k;
      logic pj;
      k = 0;
      pj = 1'b0;
      forever begin
         @(negedge clk);
         if (rst2) begin
            k = 0; jdata2 = 1'b1; pj = 1'b0;
         end else begin
            if (jclk2 && !pj) begin
               if (!jload2) begin
                  k = 0;
                  fpat2 = next_pat2;
               end else k++;
               jdata2 = slot_bit(k + 1, 0, W2, 64'(fpat2));
            end
            pj = jclk2;
         end
      end
   end

   // Timing model: counts enabled cycles since reset; the m-th divider tick lands
   // on enabled cycle m*SD, odd ticks are rises, every TOTAL-th rise ends a frame.
   initial begin : p_model
      int           e, m, r;
      logic         cp, ec, ena_s, rst_s, exp_clk, exp_load, same;
      logic [W-1:0] pw, ej;
      logic [W-1:0] hist[$];
      e = 0; cp = 1'b0; ec = 1'b0; ej = '1; pw = '1;
      forever begin
         @(posedge clk);
         ena_s = ena;
         rst_s = rst;
         @(negedge clk);
         if (rst || rst_s) begin
            e = 0; cp = 1'b0; ec = 1'b0; ej = '1;
            hist.delete();
         end else begin
            ec = 1'b0;
            if (cp) begin
               hist.push_back(pw);
               if (hist.size() > DEB) void'(hist.pop_front());
               same = (hist.size() == DEB);
               foreach (hist[i]) if (hist[i] != pw) same = 1'b0;
               if (same && pw != ej) begin
                  ej = pw;
                  ec = 1'b1;
               end
               cp = 1'b0;
            end
            if (ena_s) begin
               e++;
               if ((e % SD) == 0 && ((e / SD) % 2) == 1 && ((((e / SD) + 1) / 2) % TOTAL) == 0) begin
                  cp = 1'b1;
                  pw = fpat;
               end
            end
         end
         m = e / SD;
         r = (m + 1) / 2;
         exp_clk  = ((m % 2) == 1);
         exp_load = (r == 0) ? 1'b1 : (((r - 1) % TOTAL) != 0);
         chk("cycle", 64'({jclk, jload, oframe, ochg, ojoy}),
             64'({exp_clk, exp_load, cp, ec, ej}));
      end
   end

   task automatic wait_frame(output int at);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!oframe && n < 700);
      chk("frame_wait", 64'(oframe), 64'(1));
      at = cyc;
   endtask

   task automatic wait_load_low();
      int n;
      n = 0;
      while (jload && n < 700) begin
         @(posedge clk); #1;
         n++;
      end
      chk("load_wait", 64'(jload), 64'(0));
   endtask

   task automatic wait_rises(input int cnt);
      int   seen, n;
      logic p;
      seen = 0; n = 0; p = jclk;
      while (seen < cnt && n < 100 * cnt) begin
         @(posedge clk); #1;
         n++;
         if (jclk && !p) seen++;
         p = jclk;
      end
      chk("rise_wait", 64'(seen), 64'(cnt));
   endtask

   initial begin : p_dut2
      int c;
      next_pat2 = 32'h0123_4567;
      repeat (3) @(posedge clk);
      #1;
      chk("d2_rst_joy", 64'(ojoy2), 64'(32'hFFFF_FFFF));
      rst2 = 1'b0;
      c = 0;
      do begin
         @(posedge clk); #1;
         c++;
      end while (!oframe2 && c < 600);
      chk("d2_frame_cycle", 64'(c), 64'(260));
      @(posedge clk); #1;
      chk("d2_joy", 64'(ojoy2), 64'(32'h0123_4567));
      chk("d2_chg", 64'(ochg2), 64'(1));
      done2 = 1'b1;
   end

   initial begin : p_stim
      int rel, f1, f2, f3, f5, f6, f7, n, cb;
      next_pat = 24'hA5C3F0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_joy",   64'(ojoy),   64'(24'hFFFFFF));
      chk("rst_load",  64'(jload),  64'(1));
      chk("rst_clk",   64'(jclk),   64'(0));
      chk("rst_frame", 64'(oframe), 64'(0));
      chk("rst_chg",   64'(ochg),   64'(0));
      rst = 1'b0;
      rel = cyc;

      wait_frame(f1);
      chk("first_frame_cycle", 64'(f1 - rel), 64'(204));
      @(posedge clk); #1;
      chk("frame1_joy", 64'(ojoy), 64'(24'hFFFFFF));
      wait_frame(f2);
      chk("frame_period", 64'(f2 - f1), 64'(208));
      chk("load_low_len", 64'(last_low), 64'(8));
      @(posedge clk); #1;
      chk("frame2_joy", 64'(ojoy), 64'(24'hA5C3F0));
      chk("frame2_chg", 64'(ochg), 64'(1));
      @(posedge clk); #1;
      chk("chg_one_cycle", 64'(ochg), 64'(0));

      // One frame with bit 5 pulled low, then back to the steady pattern.
      cb = chg_count;
      next_pat = 24'hA5C3D0;
      wait_frame(f3);
      next_pat = 24'hA5C3F0;
      wait_frame(n);
      wait_frame(f5);
      chk("glitch_frames", 64'(f5 - f3), 64'(416));
      chk("glitch_no_change", 64'(chg_count - cb), 64'(0));
      chk("glitch_joy", 64'(ojoy), 64'(24'hA5C3F0));

      next_pat = 24'h5A3C0F;
      wait_load_low();
      wait_rises(13);
      ena = 1'b0;
      repeat (37) @(posedge clk);
      #1;
      ena = 1'b1;
      wait_frame(f6);
      chk("pause_frame_len", 64'(f6 - f5), 64'(245));
      wait_frame(f7);
      chk("post_pause_period", 64'(f7 - f6), 64'(208));
      @(posedge clk); #1;
      chk("pause_joy", 64'(ojoy), 64'(24'h5A3C0F));

      wait_load_low();
      wait_rises(10);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      next_pat = '1;
      #1;
      chk("midrst_joy",  64'(ojoy),  64'(24'hFFFFFF));
      chk("midrst_load", 64'(jload), 64'(1));
      chk("midrst_clk",  64'(jclk),  64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (jload && n < 50);
      chk("rst_first_load", 64'(n), 64'(SD));

      cb = chg_count;
      wait_frame(n);
      wait_frame(n);
      wait_frame(n);
      @(posedge clk); #1;
      chk("unplugged_no_change", 64'(chg_count - cb), 64'(0));
      chk("unplugged_joy", 64'(ojoy), 64'(24'hFFFFFF));

      n = 0;
      while (!done2 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("d2_done", 64'(done2), 64'(1));

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
`default_nettype wire
